// File: rtl/score_display_scanner.sv
// Score display scanner: binary-to-BCD double-dabble plus 8-digit scan.
// Optional LEADING_ZERO_BLANK_EN macro blanks leading zero digits.
module score_display_scanner #(
    parameter int SCAN_DIV   = 100000,
    parameter int NUM_DIGITS = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [26:0] value,
    input  logic        load,
    output logic        ready,
    output logic        done,
    output logic [3:0]  digit_data,
    output logic [2:0]  display_select
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [2:0]    SEL_LAST   = 3'(NUM_DIGITS - 1);
    localparam logic [26:0]   MAX_VAL    = 27'd99_999_999;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_COMMIT
    } state_e;

    state_e         state_q, state_d;
    logic [26:0]    bin_q, bin_d;
    logic [31:0]    bcd_q, bcd_d;
    logic [4:0]     iter_q, iter_d;
    logic [31:0]    disp_q, disp_d;
    logic           done_q, done_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [2:0]     sel_q, sel_d;
    logic [31:0]    adj;
    logic [3:0]     digit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            iter_q  <= '0;
            disp_q  <= '0;
            done_q  <= 1'b0;
            presc_q <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
            disp_q  <= disp_d;
            done_q  <= done_d;
            presc_q <= presc_d;
            sel_q   <= sel_d;
        end
    end

    // Add-3 correction applied before each shift
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 8; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        disp_d  = disp_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (load) begin
                    bin_d   = (value > MAX_VAL) ? MAX_VAL : value;
                    bcd_d   = '0;
                    iter_d  = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                {bcd_d, bin_d} = {adj[30:0], bin_q, 1'b0};
                iter_d = iter_q + 5'd1;
                if (iter_q == 5'd26) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                disp_d  = bcd_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        presc_d = presc_q + PW'(1);
        sel_d   = sel_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            sel_d   = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
        end
    end

    assign digit = disp_q[{sel_q, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic [7:0] tail_zero;
    logic       run_zero;

    // tail_zero[i]: digits i..NUM_DIGITS-1 of the buffer are all zero
    always_comb begin
        tail_zero = '0;
        run_zero  = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (i < NUM_DIGITS) begin
                run_zero = run_zero & (disp_q[4*i +: 4] == 4'd0);
            end
            tail_zero[i] = run_zero;
        end
    end

    assign digit_data = ((sel_q != 3'd0) && tail_zero[sel_q]) ? 4'hF : digit;
`else
    assign digit_data = digit;
`endif

    assign ready          = (state_q == S_IDLE);
    assign done           = done_q;
    assign display_select = sel_q;

endmodule

// File: tb/tb_score_display_scanner.sv
// Bench for score_display_scanner: directed and random loads
// checked against a decimal arithmetic model of the display.
module tb_score_display_scanner;

    logic        clk = 1'b0;
    logic        resetn;
    logic [26:0] value;
    logic        load;
    logic        ready, done;
    logic [3:0]  digit_data;
    logic [2:0]  display_select;
    logic        ready2, done2;
    logic [3:0]  digit_data2;
    logic [2:0]  display_select2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    score_display_scanner #(.SCAN_DIV(3), .NUM_DIGITS(8)) dut (
        .clk(clk), .resetn(resetn), .value(value), .load(load),
        .ready(ready), .done(done), .digit_data(digit_data),
        .display_select(display_select)
    );

    score_display_scanner #(.SCAN_DIV(4), .NUM_DIGITS(6)) dut_scan (
        .clk(clk), .resetn(resetn), .value(27'd0), .load(1'b0),
        .ready(ready2), .done(done2), .digit_data(digit_data2),
        .display_select(display_select2)
    );

    function automatic logic [3:0] model_digit(longint v, int k);
        longint s;
        longint p;
        s = (v > 99999999) ? 99999999 : v;
        p = 1;
        for (int j = 0; j < k; j++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (k >= 1 && (s / p) == 0) return 4'hF;
`endif
        return 4'((s / p) % 10);
    endfunction

    task automatic chk(string tag, longint obs, longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(logic [26:0] v);
        value = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic wait_done(string tag);
        int lat;
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            lat++;
            if (done) break;
        end
        chk({tag, "_latency"}, lat, 28);
        chk({tag, "_ready_at_done"}, ready, 1);
    endtask

    task automatic read_digits(string tag, longint v);
        bit found;
        for (int k = 0; k < 8; k++) begin
            found = 0;
            for (int c = 0; c < 40; c++) begin
                if (display_select == 3'(k)) begin
                    found = 1;
                    break;
                end
                tick();
            end
            chk($sformatf("%s_sel%0d_seen", tag, k), found, 1);
            chk($sformatf("%s_dig%0d", tag, k), digit_data,
                model_digit(v, k));
        end
    endtask

    initial begin
        int     ndone;
        int     first;
        longint rv;

        resetn = 1'b0;
        load   = 1'b0;
        value  = '0;
        repeat (3) tick();
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_sel", display_select, 0);
        chk("rst_digit", digit_data, 0);
        chk("rst_sel2", display_select2, 0);
        resetn = 1'b1;

        for (int n = 1; n <= 48; n++) begin
            tick();
            chk($sformatf("scan6_n%0d", n), display_select2, (n / 4) % 6);
            chk($sformatf("scan8_n%0d", n), display_select, (n / 3) % 8);
        end

        start(27'd1234);
        chk("conv_busy", ready, 0);
        wait_done("l1234");
        tick();
        chk("done_one_cycle", done, 0);
        read_digits("l1234", 1234);

        start(27'h7FFFFFF);
        wait_done("sat");
        read_digits("sat", 134217727);

        start(27'd5);
        ndone = 0;
        first = 0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 10) begin
                value = 27'd77;
                load  = 1'b1;
            end
            tick();
            load = 1'b0;
            if (done) begin
                ndone++;
                if (first == 0) first = c;
            end
        end
        chk("ign_ndone", ndone, 1);
        chk("ign_first", first, 28);
        read_digits("ign", 5);

        start(27'd4321);
        wait_done("b2b_a");
        start(27'd98765432);
        wait_done("b2b_b");
        read_digits("b2b", 98765432);

        start(27'd999);
        ndone = 0;
        repeat (14) begin
            tick();
            if (done) ndone++;
        end
        resetn = 1'b0;
        #1;
        chk("arst_ready", ready, 1);
        chk("arst_sel", display_select, 0);
        tick();
        resetn = 1'b1;
        chk("rel_done", done, 0);
        chk("rel_sel", display_select, 0);
        chk("rel_digit", digit_data, 0);
        for (int n = 1; n <= 4; n++) begin
            tick();
            chk($sformatf("rel_presc_n%0d", n), display_select, n / 3);
        end
        repeat (40) begin
            tick();
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        read_digits("abort_buf", 0);
        start(27'd999);
        wait_done("l999");
        read_digits("l999", 999);

        for (int r = 0; r < 6; r++) begin
            case (r % 3)
                0: rv = longint'($urandom_range(0, 999));
                1: rv = longint'($urandom_range(0, 99999999));
                default: rv = longint'($urandom_range(0, 134217727));
            endcase
            start(27'(rv));
            wait_done($sformatf("rnd%0d", r));
            read_digits($sformatf("rnd%0d", r), rv);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
